// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame-level controller for the RGB->YCbCr->Sobel edge pipeline.
// Tracks vsync/href/clken framing, holds threshold/mode/bypass in shadow registers and
// applies them only at frame start, checks frame geometry and keeps frame/error counters.
//
// Optional feature macro: SOBEL_CTRL_TIMEOUT_EN enables a pixel watchdog inside a frame.
//
// Ports:
//   clk, rst                       pixel clock, asynchronous active-high reset
//   ctrl_en                        process frames (0 = finish current frame, then idle)
//   per_frame_vsync/href/clken     frame / line / pixel valid
//   cfg_wr, cfg_thresh/mode/bypass shadow configuration write
//   thresh_o, mode_o, bypass_o     active configuration for the datapath
//   cfg_pending                    shadow written but not yet applied
//   frame_active                   frame in progress
//   frame_start, frame_done        1-cycle frame pulses
//   geom_err, timeout_o            1-cycle error pulses
//   frame_cnt, err_cnt             completed frames (wraps), bad frames (saturates)
module sobel_frame_ctrl #(
    parameter logic [11:0] IMG_HDISP   = 12'd1920,
    parameter logic [11:0] IMG_VDISP   = 12'd1080,
    parameter logic [7:0]  THRESH_RST  = 8'd48,
    parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_en,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        cfg_wr,
    input  logic [7:0]  cfg_thresh,
    input  logic [3:0]  cfg_mode,
    input  logic        cfg_bypass,
    output logic [7:0]  thresh_o,
    output logic [3:0]  mode_o,
    output logic        bypass_o,
    output logic        cfg_pending,
    output logic        frame_active,
    output logic        frame_start,
    output logic        frame_done,
    output logic        geom_err,
    output logic        timeout_o,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam int unsigned CNT_W = 12;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_DONE} state_t;

    state_t             state_q;
    logic               vsync_q, href_q;
    logic [CNT_W-1:0]   pix_cnt_q, line_cnt_q;
    logic               line_err_q;
    logic [7:0]         sh_thresh_q, thresh_q;
    logic [3:0]         sh_mode_q, mode_q;
    logic               sh_bypass_q, bypass_q;
    logic               pending_q, active_q, start_q, done_q, geom_q, timeout_q;
    logic [15:0]        frame_cnt_q;
    logic [7:0]         err_cnt_q;

    logic               in_active, vs_rise, vs_fall, hr_fall, pix_beat, line_end;
    logic               wd_fire, close_frame, geom_d;
    logic [CNT_W-1:0]   pix_cnt_d, line_cnt_d;
    logic               line_err_d;

    // Framing edges and next-state of the geometry counters while ACTIVE
    always_comb begin
        in_active  = (state_q == S_ACTIVE);
        vs_rise    = per_frame_vsync & ~vsync_q;
        vs_fall    = ~per_frame_vsync & vsync_q;
        hr_fall    = ~per_frame_href & href_q;
        pix_beat   = per_frame_href & per_frame_clken;
        // A vsync fall while href is still high closes a truncated line
        line_end   = hr_fall | (vs_fall & per_frame_href);
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        line_err_d = line_err_q;
        if (line_end) begin
            pix_cnt_d  = '0;
            line_cnt_d = (line_cnt_q == {CNT_W{1'b1}}) ? line_cnt_q : line_cnt_q + CNT_W'(1);
            line_err_d = line_err_q | (pix_cnt_q != IMG_HDISP) | (vs_fall & per_frame_href);
        end else if (pix_beat) begin
            pix_cnt_d  = (pix_cnt_q == {CNT_W{1'b1}}) ? pix_cnt_q : pix_cnt_q + CNT_W'(1);
        end
        close_frame = in_active & (vs_fall | wd_fire);
        geom_d      = line_err_d | (line_cnt_d != IMG_VDISP) | wd_fire;
    end

`ifdef SOBEL_CTRL_TIMEOUT_EN
    logic [15:0] wd_q;

    // Watchdog fires on the cycle the pixel-free run length reaches TIMEOUT_CYC
    assign wd_fire = in_active & ~pix_beat & (wd_q == TIMEOUT_CYC - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else if (!in_active || pix_beat || wd_fire) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 16'd1;
        end
    end
`else
    logic unused_timeout;

    assign wd_fire        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    // Frame FSM, configuration shadowing and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            line_err_q  <= 1'b0;
            sh_thresh_q <= THRESH_RST;
            sh_mode_q   <= '0;
            sh_bypass_q <= 1'b0;
            thresh_q    <= THRESH_RST;
            mode_q      <= '0;
            bypass_q    <= 1'b0;
            pending_q   <= 1'b0;
            active_q    <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            geom_q      <= 1'b0;
            timeout_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            vsync_q   <= per_frame_vsync;
            href_q    <= per_frame_href;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            geom_q    <= 1'b0;
            timeout_q <= 1'b0;

            if (cfg_wr) begin
                sh_thresh_q <= cfg_thresh;
                sh_mode_q   <= cfg_mode;
                sh_bypass_q <= cfg_bypass;
                // No frame can be in flight in IDLE, so apply immediately
                if (state_q == S_IDLE) begin
                    thresh_q <= cfg_thresh;
                    mode_q   <= cfg_mode;
                    bypass_q <= cfg_bypass;
                end else begin
                    pending_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (ctrl_en) state_q <= S_ARMED;
                end
                S_ARMED: begin
                    if (!ctrl_en) begin
                        state_q <= S_IDLE;
                    end else if (vs_rise) begin
                        state_q   <= S_ACTIVE;
                        active_q  <= 1'b1;
                        start_q   <= 1'b1;
                        pending_q <= 1'b0;
                        // A write on the start edge bypasses the shadow into this frame
                        thresh_q  <= cfg_wr ? cfg_thresh : sh_thresh_q;
                        mode_q    <= cfg_wr ? cfg_mode   : sh_mode_q;
                        bypass_q  <= cfg_wr ? cfg_bypass : sh_bypass_q;
                    end
                end
                S_ACTIVE: begin
                    pix_cnt_q  <= pix_cnt_d;
                    line_cnt_q <= line_cnt_d;
                    line_err_q <= line_err_d;
                    if (close_frame) begin
                        state_q     <= S_DONE;
                        active_q    <= 1'b0;
                        done_q      <= 1'b1;
                        geom_q      <= geom_d;
                        timeout_q   <= wd_fire;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        if (geom_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                        pix_cnt_q   <= '0;
                        line_cnt_q  <= '0;
                        line_err_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= ctrl_en ? S_ARMED : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign thresh_o     = thresh_q;
    assign mode_o       = mode_q;
    assign bypass_o     = bypass_q;
    assign cfg_pending  = pending_q;
    assign frame_active = active_q;
    assign frame_start  = start_q;
    assign frame_done   = done_q;
    assign geom_err     = geom_q;
    assign timeout_o    = timeout_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed testbench for sobel_frame_ctrl with an 8x4 frame geometry.
module tb_sobel_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_en, vsync, href, clken, cfg_wr, cfg_bypass;
    logic [7:0]  cfg_thresh;
    logic [3:0]  cfg_mode;
    logic [7:0]  thresh_o;
    logic [3:0]  mode_o;
    logic        bypass_o, cfg_pending, frame_active, frame_start, frame_done, geom_err, timeout_o;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int n_start, n_done, n_geom, n_timeout, n_geom_lone;

    sobel_frame_ctrl #(
        .IMG_HDISP   (12'd8),
        .IMG_VDISP   (12'd4),
        .THRESH_RST  (8'd48),
        .TIMEOUT_CYC (16'd16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ctrl_en         (ctrl_en),
        .per_frame_vsync (vsync),
        .per_frame_href  (href),
        .per_frame_clken (clken),
        .cfg_wr          (cfg_wr),
        .cfg_thresh      (cfg_thresh),
        .cfg_mode        (cfg_mode),
        .cfg_bypass      (cfg_bypass),
        .thresh_o        (thresh_o),
        .mode_o          (mode_o),
        .bypass_o        (bypass_o),
        .cfg_pending     (cfg_pending),
        .frame_active    (frame_active),
        .frame_start     (frame_start),
        .frame_done      (frame_done),
        .geom_err        (geom_err),
        .timeout_o       (timeout_o),
        .frame_cnt       (frame_cnt),
        .err_cnt         (err_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_start) n_start++;
            if (frame_done) n_done++;
            if (geom_err) n_geom++;
            if (timeout_o) n_timeout++;
            if (geom_err && !frame_done) n_geom_lone++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        n_start = 0; n_done = 0; n_geom = 0; n_timeout = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; ctrl_en = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0;
        cfg_wr = 1'b0; cfg_thresh = 8'd0; cfg_mode = 4'd0; cfg_bypass = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        clear_counts();
    endtask

    task automatic send_line(input int len);
        href = 1'b1; clken = 1'b1;
        tick(len);
        href = 1'b0; clken = 1'b0;
        tick(2);
    endtask

    task automatic send_lines(input int nl, input int short_idx, input int short_len);
        for (int i = 0; i < nl; i++) send_line((i == short_idx) ? short_len : 8);
    endtask

    task automatic frame_begin();
        vsync = 1'b1;
        tick(3);
    endtask

    task automatic frame_end();
        vsync = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (thresh_o !== 8'd48) begin errors++; $display("FAIL reset_thresh: got %0d expected 48", thresh_o); end
        checks++; if (mode_o !== 4'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode_o); end
        checks++; if (bypass_o !== 1'b0) begin errors++; $display("FAIL reset_bypass: got %0b expected 0", bypass_o); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if ({cfg_pending, frame_active, frame_start, frame_done, geom_err, timeout_o} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                               {cfg_pending, frame_active, frame_start, frame_done, geom_err, timeout_o});
        end
    endtask

    task automatic test_clean_frame();
        do_reset();
        ctrl_en = 1'b1;
        tick(1);
        frame_begin();
        checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL clean_active: got %0b expected 1", frame_active); end
        send_lines(4, -1, 8);
        frame_end();
        checks++; if (n_start !== 1) begin errors++; $display("FAIL clean_starts: got %0d expected 1", n_start); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL clean_dones: got %0d expected 1", n_done); end
        checks++; if (n_geom !== 0) begin errors++; $display("FAIL clean_geom: got %0d expected 0", n_geom); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL clean_frame_cnt: got %0d expected 1", frame_cnt); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL clean_idle: got %0b expected 0", frame_active); end
    endtask

    task automatic test_cfg_shadow();
        do_reset();
        ctrl_en = 1'b1;
        tick(1);
        frame_begin();
        send_lines(2, -1, 8);
        cfg_thresh = 8'd64; cfg_wr = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
        checks++; if (thresh_o !== 8'd48) begin errors++; $display("FAIL shadow_mid_thresh: got %0d expected 48", thresh_o); end
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL shadow_mid_pending: got %0b expected 1", cfg_pending); end
        send_lines(2, -1, 8);
        frame_end();
        checks++; if (thresh_o !== 8'd48) begin errors++; $display("FAIL shadow_gap_thresh: got %0d expected 48", thresh_o); end
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL shadow_gap_pending: got %0b expected 1", cfg_pending); end
        frame_begin();
        checks++; if (thresh_o !== 8'd64) begin errors++; $display("FAIL shadow_new_thresh: got %0d expected 64", thresh_o); end
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL shadow_new_pending: got %0b expected 0", cfg_pending); end
        send_lines(4, -1, 8);
        frame_end();
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL shadow_frame_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_cfg_on_start();
        do_reset();
        ctrl_en = 1'b1;
        tick(1);
        cfg_thresh = 8'd99; cfg_mode = 4'd5; cfg_wr = 1'b1; vsync = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
        checks++; if (thresh_o !== 8'd99) begin errors++; $display("FAIL start_cfg_thresh: got %0d expected 99", thresh_o); end
        checks++; if (mode_o !== 4'd5) begin errors++; $display("FAIL start_cfg_mode: got %0d expected 5", mode_o); end
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL start_cfg_pending: got %0b expected 0", cfg_pending); end
        checks++; if (n_start !== 1) begin errors++; $display("FAIL start_cfg_starts: got %0d expected 1", n_start); end
        tick(2);
        send_lines(4, -1, 8);
        frame_end();
    endtask

    task automatic test_idle_cfg();
        do_reset();
        cfg_thresh = 8'd50; cfg_mode = 4'd3; cfg_bypass = 1'b1; cfg_wr = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
        checks++; if (thresh_o !== 8'd50) begin errors++; $display("FAIL idle_cfg_thresh: got %0d expected 50", thresh_o); end
        checks++; if (mode_o !== 4'd3) begin errors++; $display("FAIL idle_cfg_mode: got %0d expected 3", mode_o); end
        checks++; if (bypass_o !== 1'b1) begin errors++; $display("FAIL idle_cfg_bypass: got %0b expected 1", bypass_o); end
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL idle_cfg_pending: got %0b expected 0", cfg_pending); end
    endtask

    task automatic test_geom_err();
        do_reset();
        ctrl_en = 1'b1;
        tick(1);
        frame_begin();
        send_lines(4, 1, 7);
        frame_end();
        checks++; if (n_geom !== 1) begin errors++; $display("FAIL geom_pulses: got %0d expected 1", n_geom); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL geom_err_cnt: got %0d expected 1", err_cnt); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL geom_frame_cnt: got %0d expected 1", frame_cnt); end
        // Three lines only: wrong line count
        frame_begin();
        send_lines(3, -1, 8);
        frame_end();
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL geom_short_frame: got %0d expected 2", err_cnt); end
        // vsync drops in the middle of the 4th line: truncated line
        frame_begin();
        send_lines(3, -1, 8);
        href = 1'b1; clken = 1'b1;
        tick(4);
        vsync = 1'b0;
        tick(1);
        href = 1'b0; clken = 1'b0;
        tick(4);
        checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL geom_truncated: got %0d expected 3", err_cnt); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL geom_frame_cnt3: got %0d expected 3", frame_cnt); end
    endtask

    task automatic test_arm_late();
        do_reset();
        vsync = 1'b1;
        tick(3);
        ctrl_en = 1'b1;
        tick(5);
        checks++; if (n_start !== 0) begin errors++; $display("FAIL late_arm_start: got %0d expected 0", n_start); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL late_arm_active: got %0b expected 0", frame_active); end
        vsync = 1'b0;
        tick(2);
        frame_begin();
        checks++; if (n_start !== 1) begin errors++; $display("FAIL late_arm_rise: got %0d expected 1", n_start); end
        send_lines(2, -1, 8);
        ctrl_en = 1'b0;
        send_lines(2, -1, 8);
        frame_end();
        checks++; if (n_done !== 1) begin errors++; $display("FAIL disable_done: got %0d expected 1", n_done); end
        checks++; if (n_geom !== 0) begin errors++; $display("FAIL disable_geom: got %0d expected 0", n_geom); end
        frame_begin();
        checks++; if (n_start !== 1) begin errors++; $display("FAIL disable_idle: got %0d expected 1", n_start); end
        frame_end();
    endtask

    task automatic test_reset_midframe();
        do_reset();
        ctrl_en = 1'b1;
        tick(1);
        frame_begin();
        send_line(8);
        cfg_thresh = 8'd70; cfg_wr = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
        send_line(8);
        rst = 1'b1;
        #1;
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL rst_mid_active: got %0b expected 0", frame_active); end
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL rst_mid_pending: got %0b expected 0", cfg_pending); end
        checks++; if (thresh_o !== 8'd48) begin errors++; $display("FAIL rst_mid_thresh: got %0d expected 48", thresh_o); end
        tick(2);
        rst = 1'b0;
        clear_counts();
        tick(5);
        checks++; if (n_start !== 0) begin errors++; $display("FAIL rst_mid_no_start: got %0d expected 0", n_start); end
        vsync = 1'b0;
        tick(2);
        frame_begin();
        send_lines(4, -1, 8);
        frame_end();
        checks++; if (n_start !== 1) begin errors++; $display("FAIL rst_mid_restart: got %0d expected 1", n_start); end
        checks++; if (n_geom !== 0) begin errors++; $display("FAIL rst_mid_geom: got %0d expected 0", n_geom); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rst_mid_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

`ifdef SOBEL_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        ctrl_en = 1'b1;
        tick(1);
        vsync = 1'b1;
        tick(20);
        checks++; if (n_timeout !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d expected 1", n_timeout); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL timeout_done: got %0d expected 1", n_done); end
        checks++; if (n_geom !== 1) begin errors++; $display("FAIL timeout_geom: got %0d expected 1", n_geom); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL timeout_err_cnt: got %0d expected 1", err_cnt); end
        vsync = 1'b0;
        tick(3);
    endtask
`endif

    initial begin
        n_geom_lone = 0;
        test_reset();
        test_clean_frame();
        test_cfg_shadow();
        test_cfg_on_start();
        test_idle_cfg();
        test_geom_err();
        test_arm_late();
        test_reset_midframe();
`ifdef SOBEL_CTRL_TIMEOUT_EN
        test_timeout();
`else
        checks++; if (n_timeout !== 0) begin errors++; $display("FAIL no_timeout: got %0d expected 0", n_timeout); end
`endif
        checks++; if (n_geom_lone !== 0) begin errors++; $display("FAIL geom_without_done: got %0d expected 0", n_geom_lone); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
